// File: rtl/openila_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : openila_capture_ctrl_pkg
//  Purpose  : Shared state encoding for the ILA capture controller.
//  Revision : 1.0
// ============================================================================
package openila_capture_ctrl_pkg;

    localparam int W_STATE = 3;

    typedef enum logic [W_STATE-1:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    // States in which the controller owns the memory port for writing.
    function automatic logic is_capture(input state_t s);
        return (s == ST_FILL) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/openila_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : openila_capture_ctrl
//  Purpose  : Trace-buffer sequencer: pre-trigger fill, circular capture,
//             post-trigger fill, then oldest-first readout of DEPTH samples.
//  Revision : 1.0
// ============================================================================
module openila_capture_ctrl
    import openila_capture_ctrl_pkg::*;
#(
    parameter int W_DATA = 8,
    parameter int W_ADDR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DATA-1:0] sample_data,
    input  logic              sample_valid,
    input  logic              trigger,
    input  logic              arm,
    input  logic              abort,
    input  logic [W_ADDR-1:0] cfg_pretrig,
    output logic [W_ADDR-1:0] mem_addr,
    output logic              mem_wen,
    output logic [W_DATA-1:0] mem_wdata,
    input  logic [W_DATA-1:0] mem_rdata,
    output logic [W_DATA-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [W_ADDR-1:0] trig_addr,
    output logic [W_STATE-1:0] status_state
);

    localparam int              DEPTH = 1 << W_ADDR;
    localparam logic [W_ADDR-1:0] C_MAX = W_ADDR'(DEPTH - 1);
    localparam logic [W_ADDR-1:0] C_ONE = W_ADDR'(1);

    state_t            r_state,     w_state_nxt;
    logic [W_ADDR-1:0] r_wr_ptr,    w_wr_ptr_nxt;
    logic [W_ADDR-1:0] r_rd_ptr,    w_rd_ptr_nxt;
    logic [W_ADDR-1:0] r_cnt,       w_cnt_nxt;
    logic [W_ADDR-1:0] r_pre,       w_pre_nxt;
    logic [W_ADDR-1:0] r_post,      w_post_nxt;
    logic [W_ADDR-1:0] r_trig_addr, w_trig_addr_nxt;
    logic              r_out_valid, w_out_valid_nxt;

    logic w_wr;
    logic w_hs;
    logic w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_pre       <= '0;
            r_post      <= '0;
            r_trig_addr <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pre       <= w_pre_nxt;
            r_post      <= w_post_nxt;
            r_trig_addr <= w_trig_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_cnt_nxt       = r_cnt;
        w_pre_nxt       = r_pre;
        w_post_nxt      = r_post;
        w_trig_addr_nxt = r_trig_addr;
        w_out_valid_nxt = r_out_valid;
        mem_addr        = r_wr_ptr;
        mem_wdata       = sample_data;
        // abort outranks everything, including the write in its own cycle
        w_wr            = sample_valid & ~abort;
        mem_wen         = is_capture(r_state) & w_wr;
        w_hs            = r_out_valid & out_ready;
        w_last          = (r_state == ST_READ) & r_out_valid & (r_cnt == C_MAX);

        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_pre_nxt    = cfg_pretrig;
                    w_wr_ptr_nxt = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = (cfg_pretrig == '0) ? ST_ARMED : ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_wr) begin
                    w_wr_ptr_nxt = r_wr_ptr + C_ONE;
                    w_cnt_nxt    = r_cnt + C_ONE;
                    if ((r_cnt + C_ONE) == r_pre)
                        w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_wr) begin
                    w_wr_ptr_nxt = r_wr_ptr + C_ONE;
                    if (trigger) begin
                        w_trig_addr_nxt = r_wr_ptr;
                        w_post_nxt      = C_MAX - r_pre;
                        if (r_pre == C_MAX) begin
                            w_state_nxt     = ST_READ;
                            w_rd_ptr_nxt    = r_wr_ptr - r_pre;
                            w_cnt_nxt       = '0;
                            w_out_valid_nxt = 1'b0;
                        end else begin
                            w_state_nxt = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (w_wr) begin
                    w_wr_ptr_nxt = r_wr_ptr + C_ONE;
                    w_post_nxt   = r_post - C_ONE;
                    if (r_post == C_ONE) begin
                        w_state_nxt     = ST_READ;
                        w_rd_ptr_nxt    = r_trig_addr - r_pre;
                        w_cnt_nxt       = '0;
                        w_out_valid_nxt = 1'b0;
                    end
                end
            end
            ST_READ: begin
                // Address looks one ahead on a handshake so the next word
                // arrives in time for back-to-back transfers.
                mem_addr        = w_hs ? (r_rd_ptr + C_ONE) : r_rd_ptr;
                w_out_valid_nxt = 1'b1;
                if (w_hs) begin
                    w_rd_ptr_nxt = r_rd_ptr + C_ONE;
                    w_cnt_nxt    = r_cnt + C_ONE;
                    if (w_last) begin
                        w_state_nxt     = ST_IDLE;
                        w_out_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase

        if (abort) begin
            w_state_nxt     = ST_IDLE;
            w_out_valid_nxt = 1'b0;
        end
    end

    assign out_data     = mem_rdata;
    assign out_valid    = r_out_valid;
    assign out_last     = w_last;
    assign trig_addr    = r_trig_addr;
    assign status_state = r_state;

endmodule
`default_nettype wire
